// File: rtl/sonido_pkg.sv
// sonido_pkg: game state codes, note codes and jingle ROM for the buzzer sequencer
package sonido_pkg;

    typedef enum logic [2:0] {G_OFF, G_WLCM, G_CH, G_GAME, G_WL, G_PA} game_t;

    localparam logic [2:0] N_SIL = 3'd0;
    localparam logic [2:0] N_FA  = 3'd1;
    localparam logic [2:0] N_RE  = 3'd2;
    localparam logic [2:0] N_SOL = 3'd3;
    localparam logic [2:0] N_DO  = 3'd4;
    localparam logic [2:0] N_SIB = 3'd5;

    typedef enum logic [1:0] {M_WLCM, M_WIN, M_LOSE} mel_t;

    typedef struct packed {
        logic [2:0] nota;
        logic [9:0] dur;
    } step_t;

    localparam step_t MEL_ROM [3][4] = '{
        '{'{N_DO,  10'd200}, '{N_FA,  10'd200}, '{N_SOL, 10'd200}, '{N_SIB, 10'd400}},
        '{'{N_SOL, 10'd150}, '{N_SIB, 10'd150}, '{N_DO,  10'd150}, '{N_SIB, 10'd400}},
        '{'{N_SOL, 10'd250}, '{N_FA,  10'd250}, '{N_RE,  10'd250}, '{N_DO,  10'd500}}
    };

    function automatic step_t rom_step(input mel_t m, input logic [1:0] s);
        return MEL_ROM[m][s];
    endfunction

endpackage

// File: rtl/tick_gen_ms.sv
// tick_gen_ms: one-cycle tick every TICK_DIV clocks (1 ms at 27 MHz by default)
module tick_gen_ms #(
    parameter int TICK_DIV = 27000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int W = $clog2(TICK_DIV);

    logic [W-1:0] cnt;

    assign tick = cnt == W'(TICK_DIV - 1);

    // free-running divider, wraps on the tick
    always_ff @(posedge clk) cnt <= (rst || tick) ? '0 : cnt + 1'b1;

endmodule

// File: rtl/melodia_seq.sv
// melodia_seq: plays game jingles as timed note steps; define MELODIA_KEYBEEP_EN to add the idle keypad beep
module melodia_seq
    import sonido_pkg::*;
#(
    parameter int TICK_DIV = 27000,
    parameter int BEEP_MS  = 100,
    parameter int GAP_MS   = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] presente,
    input  logic [1:0] W_or_L,
    input  logic       keypad_pressed,
    output logic [2:0] nota,
    output logic       busy,
    output logic       done
);
    typedef enum logic [2:0] {S_IDLE, S_NOTE, S_GAP, S_PAUSED, S_BEEP} st_t;

    st_t        state, state_n, ph, ph_n;
    mel_t       mel, mel_n, trig_mel;
    game_t      src;
    step_t      cur;
    logic [1:0] step, step_n;
    logic [9:0] ms, ms_n, ms_inc;
    logic [2:0] prev;
    logic       tick, trig, kp_edge, done_n;

    tick_gen_ms #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));

`ifdef MELODIA_KEYBEEP_EN
    logic kp_prev;
    // keypad history for rising-edge detection
    always_ff @(posedge clk) kp_prev <= rst ? 1'b0 : keypad_pressed;
    assign kp_edge = keypad_pressed && !kp_prev;
`else
    logic unused_kp;
    assign unused_kp = keypad_pressed;
    assign kp_edge   = 1'b0;
`endif

    assign src      = mel == M_WLCM ? G_WLCM : G_WL;
    assign cur      = rom_step(mel, step);
    assign ms_inc   = ms + 10'd1;
    assign trig     = (presente == G_WLCM && prev != G_WLCM) ||
                      (presente == G_WL && prev != G_WL && (W_or_L == 2'b01 || W_or_L == 2'b10));
    assign trig_mel = presente == G_WLCM ? M_WLCM : W_or_L == 2'b01 ? M_WIN : M_LOSE;

    // state register plus step/ms datapath and previous-state history
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            ph    <= S_NOTE;
            mel   <= M_WLCM;
            step  <= '0;
            ms    <= '0;
            prev  <= G_OFF;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            ph    <= ph_n;
            mel   <= mel_n;
            step  <= step_n;
            ms    <= ms_n;
            prev  <= presente;
            done  <= done_n;
        end
    end

    // next state: state changes take priority over the tick, triggers over keypad edges
    always_comb begin
        state_n = state;
        ph_n    = ph;
        mel_n   = mel;
        step_n  = step;
        ms_n    = ms;
        done_n  = 1'b0;
        case (state)
            S_IDLE, S_BEEP: begin
                if (trig) begin
                    state_n = S_NOTE;
                    mel_n   = trig_mel;
                    step_n  = '0;
                    ms_n    = '0;
                end else if (state == S_IDLE && kp_edge) begin
                    state_n = S_BEEP;
                    ms_n    = '0;
                end else if (state == S_BEEP && tick) begin
                    state_n = ms_inc == 10'(BEEP_MS) ? S_IDLE : S_BEEP;
                    ms_n    = ms_inc;
                end
            end
            S_NOTE, S_GAP: begin
                if (presente == G_PA) begin
                    state_n = S_PAUSED;
                    ph_n    = state;
                end else if (presente != src) begin
                    state_n = S_IDLE;
                end else if (tick && state == S_NOTE) begin
                    state_n = ms_inc == cur.dur ? S_GAP : S_NOTE;
                    ms_n    = ms_inc == cur.dur ? '0 : ms_inc;
                end else if (tick) begin
                    state_n = ms_inc != 10'(GAP_MS) ? S_GAP : step == 2'd3 ? S_IDLE : S_NOTE;
                    ms_n    = ms_inc == 10'(GAP_MS) ? '0 : ms_inc;
                    step_n  = ms_inc == 10'(GAP_MS) && step != 2'd3 ? step + 2'd1 : step;
                    done_n  = ms_inc == 10'(GAP_MS) && step == 2'd3;
                end
            end
            S_PAUSED: begin
                state_n = presente == src ? ph : presente != G_PA ? S_IDLE : S_PAUSED;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // outputs decoded from the registered state
    always_comb begin
        nota = state == S_NOTE ? cur.nota : state == S_BEEP ? N_FA : N_SIL;
        busy = state != S_IDLE;
    end

endmodule

// File: tb/tb_melodia_seq.sv
// tb_melodia_seq: directed and random stimulus against a segment-queue model of the jingle player
module tb_melodia_seq;
    localparam int TD = 10, BEEP = 100, GAP = 20;
    localparam int MI = 0, MP = 1, MZ = 2, MB = 3;
`ifdef MELODIA_KEYBEEP_EN
    localparam bit KB = 1'b1;
`else
    localparam bit KB = 1'b0;
`endif

    logic       clk = 1'b0, rst = 1'b1, keypad_pressed = 1'b0;
    logic [2:0] presente = 3'd0;
    logic [1:0] W_or_L = 2'd0;
    logic [2:0] nota;
    logic       busy, done;

    melodia_seq #(.TICK_DIV(TD), .BEEP_MS(BEEP), .GAP_MS(GAP)) dut (
        .clk(clk), .rst(rst), .presente(presente), .W_or_L(W_or_L),
        .keypad_pressed(keypad_pressed), .nota(nota), .busy(busy), .done(done)
    );

    initial forever #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    bit chk_en = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_range(input string nm, input int act, input int lo, input int hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // model: a melody is a queue of (note, ticks) segments consumed one tick at a time
    int notes [3][4] = '{'{4, 1, 3, 5}, '{3, 5, 4, 5}, '{3, 1, 2, 4}};
    int durs  [3][4] = '{'{200, 200, 200, 400}, '{150, 150, 150, 400}, '{250, 250, 250, 500}};
    int mq_note[$], mq_len[$];
    int m_left, m_mode = MI, m_src, m_cnt, m_prev;
    bit m_kp, tk, ent_w, ent_l, edge_k;
    int e_nota = 0;
    bit e_busy = 0, e_done = 0;

    task automatic load(input int m);
        mq_note.delete();
        mq_len.delete();
        for (int s = 0; s < 4; s++) begin
            mq_note.push_back(notes[m][s]);
            mq_len.push_back(durs[m][s]);
            mq_note.push_back(0);
            mq_len.push_back(GAP);
        end
        m_left = mq_len[0];
        m_mode = MP;
        m_src  = m == 0 ? 1 : 4;
    endtask

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_cnt = 0; m_prev = 0; m_kp = 0; m_mode = MI; e_done = 0;
            mq_note.delete(); mq_len.delete();
        end else begin
            tk     = m_cnt == TD - 1;
            m_cnt  = tk ? 0 : m_cnt + 1;
            e_done = 0;
            ent_w  = presente == 3'd1 && m_prev != 1;
            ent_l  = presente == 3'd4 && m_prev != 4 && (W_or_L == 2'd1 || W_or_L == 2'd2);
            edge_k = KB && keypad_pressed && !m_kp;
            if ((m_mode == MI || m_mode == MB) && (ent_w || ent_l)) begin
                load(ent_w ? 0 : W_or_L == 2'd1 ? 1 : 2);
            end else if (m_mode == MI && edge_k) begin
                mq_note.delete(); mq_len.delete();
                mq_note.push_back(1); mq_len.push_back(BEEP);
                m_left = BEEP; m_mode = MB;
            end else if (m_mode == MB) begin
                if (tk) begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_mode = MI;
                end
            end else if (m_mode == MP) begin
                if (presente == 3'd5) m_mode = MZ;
                else if (int'(presente) != m_src) m_mode = MI;
                else if (tk) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        void'(mq_note.pop_front());
                        void'(mq_len.pop_front());
                        if (mq_len.size() == 0) begin
                            m_mode = MI; e_done = 1;
                        end else m_left = mq_len[0];
                    end
                end
            end else if (m_mode == MZ) begin
                if (int'(presente) == m_src) m_mode = MP;
                else if (presente != 3'd5) m_mode = MI;
            end
            m_prev = int'(presente);
            m_kp   = keypad_pressed;
        end
        e_nota = (m_mode == MP || m_mode == MB) && mq_note.size() > 0 ? mq_note[0] : 0;
        e_busy = m_mode != MI;
    end

    // every-cycle comparison against the model, away from the active edge
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("nota", int'(nota), e_nota);
            check("busy", int'(busy), int'(e_busy));
            check("done", int'(done), int'(e_done));
        end
    end

    int rv[$], rl[$];
    int bcnt;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic play_until_done(input int limit, output bit ok);
        int last = -1;
        ok = 0; bcnt = 0; rv.delete(); rl.delete();
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            if (done === 1'b1) ok = 1;
            else if (busy === 1'b1) begin
                bcnt++;
                if (int'(nota) != last) begin
                    rv.push_back(int'(nota)); rl.push_back(1); last = int'(nota);
                end else rl[rl.size()-1] = rl[rl.size()-1] + 1;
            end
        end
    endtask

    function automatic int seq_code();
        int a = 0;
        if (rv.size() > 9) return -1;
        foreach (rv[i]) a = a * 10 + rv[i];
        return a;
    endfunction

    task automatic wait_nota(input int v, input int limit, input string nm);
        bit f = 0;
        for (int i = 0; i < limit && !f; i++) begin
            @(negedge clk);
            f = int'(nota) == v;
        end
        if (!f) check(nm, int'(nota), v);
    endtask

    bit ok;
    int on_cnt, rises, dcnt;
    bit lastn;

    initial begin
        cyc(3);
        chk_en = 1;
        check("reset_nota", int'(nota), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        rst = 0;
        cyc(7);

        // welcome jingle
        presente = 3'd1;
        cyc(1);
        check("model_first_note", e_nota, 4);
        check("wlcm_first_note", int'(nota), 4);
        play_until_done(12000, ok);
        check("wlcm_done_seen", int'(ok), 1);
        check("wlcm_busy_at_done", int'(busy), 0);
        check("wlcm_seq", seq_code(), 40103050);
        chk_range("wlcm_busy_cycles", bcnt, 10790, 10799);
        cyc(1);
        check("wlcm_done_one_cycle", int'(done), 0);

        // lose jingle
        presente = 3'd3;
        cyc(3);
        W_or_L = 2'd2; presente = 3'd4;
        play_until_done(15000, ok);
        check("lose_done_seen", int'(ok), 1);
        check("lose_seq", seq_code(), 30102040);
        chk_range("lose_busy_cycles", bcnt, 13291, 13300);

        // win jingle paused in the first SIB, then resumed
        presente = 3'd3;
        cyc(5);
        W_or_L = 2'd1; presente = 3'd4;
        wait_nota(5, 5000, "win_reach_sib");
        cyc(499);
        presente = 3'd5;
        cyc(2);
        check("pause_nota", int'(nota), 0);
        check("pause_busy", int'(busy), 1);
        cyc(3000);
        check("pause_held_busy", int'(busy), 1);
        presente = 3'd4;
        play_until_done(12000, ok);
        check("resume_done_seen", int'(ok), 1);
        check("resume_seq", seq_code(), 504050);
        chk_range("resume_sib_len", rl.size() > 0 ? rl[0] : 0, 980, 1020);

        // abort mid-note
        presente = 3'd3;
        cyc(5);
        presente = 3'd1;
        wait_nota(1, 5000, "abort_reach_fa");
        cyc(100);
        presente = 3'd3;
        cyc(1);
        check("abort_nota", int'(nota), 0);
        check("abort_busy", int'(busy), 0);
        dcnt = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
        end
        check("abort_no_done", dcnt, 0);

        // keypad beep with the key held
        keypad_pressed = 1'b1;
        on_cnt = 0; rises = 0; lastn = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (nota == 3'd1) on_cnt++;
            if (nota == 3'd1 && !lastn) rises++;
            lastn = nota == 3'd1;
        end
        check("beep_count", rises, KB ? 1 : 0);
        chk_range("beep_len", on_cnt, KB ? 991 : 0, KB ? 1000 : 0);
        keypad_pressed = 1'b0;
        cyc(3);

        // trigger and key edge together, then reset mid-note
        keypad_pressed = 1'b1; presente = 3'd1;
        cyc(1);
        check("trig_beats_key", int'(nota), 4);
        cyc(1500);
        rst = 1;
        cyc(1);
        check("rst_mid_nota", int'(nota), 0);
        check("rst_mid_busy", int'(busy), 0);
        rst = 0; keypad_pressed = 1'b0; presente = 3'd0;
        cyc(5);

        // random traffic checked by the model
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 9))
                0: presente = 3'd0;
                1, 2: presente = 3'd1;
                3: presente = 3'd2;
                4, 9: presente = 3'd3;
                5, 6: presente = 3'd4;
                default: presente = 3'd5;
            endcase
            W_or_L = 2'($urandom_range(0, 3));
            keypad_pressed = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 24) == 0) begin
                rst = 1; cyc(1); rst = 0;
            end
            cyc($urandom_range(1, 400));
        end

        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
